pipelined_barrel_shifter: RTL and testbench



---
 rtl/pipelined_barrel_shifter.sv | 146 ++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: logical, arithmetic and rotate shifts in either direction,
// with the log2 mux tree split into registered stages behind a valid/ready handshake.
module pipelined_barrel_shifter #(
    parameter int WIDTH            = 32,
    parameter int SHIFTW           = $clog2(WIDTH),
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAGW             = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [SHIFTW:0]   shift_amt,
    input  logic              direction,
    input  logic [1:0]        op,
    input  logic [TAGW-1:0]   tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic [TAGW-1:0]   tag_out,
    output logic              op_err
);

    localparam int DEPTH   = (SHIFTW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
    localparam int AMT_EXT = DEPTH * LEVELS_PER_STAGE;

    localparam logic [1:0] OP_ARI = 2'b01;
    localparam logic [1:0] OP_ROT = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    generate
        if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 4");
        end
        if (SHIFTW != $clog2(WIDTH)) begin : g_bad_shiftw
            $error("pipelined_barrel_shifter: SHIFTW is derived from WIDTH and must not be overridden");
        end
        if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > SHIFTW) begin : g_bad_levels
            $error("pipelined_barrel_shifter: LEVELS_PER_STAGE must be in 1..SHIFTW");
        end
    endgenerate

    // Saturated result for amounts >= WIDTH on non-rotate ops.
    function automatic logic [WIDTH-1:0] sat_fill(input logic [WIDTH-1:0] d,
                                                  input logic dir,
                                                  input logic [1:0] o);
        if (dir && o == OP_ARI) return {WIDTH{d[WIDTH-1]}};
        return '0;
    endfunction

    // One mux level: shift/rotate by n (n < WIDTH).
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input int n,
                                                     input logic dir,
                                                     input logic [1:0] o);
        logic signed [WIDTH-1:0] sd;
        sd = d;
        if (o == OP_ROT) begin
            if (dir) return (d >> n) | (d << (WIDTH - n));
            return (d << n) | (d >> (WIDTH - n));
        end
        if (dir && o == OP_ARI) return sd >>> n;
        if (dir) return d >> n;
        return d << n;
    endfunction

    logic              vld_p  [DEPTH];
    logic [WIDTH-1:0]  data_p [DEPTH];
    logic [SHIFTW-1:0] amt_p  [DEPTH];
    logic              dir_p  [DEPTH];
    logic [1:0]        op_p   [DEPTH];
    logic [TAGW-1:0]   tag_p  [DEPTH];
    logic              err_p  [DEPTH];

    logic [WIDTH-1:0]   src_data [DEPTH];
    logic [SHIFTW-1:0]  src_amt  [DEPTH];
    logic               src_dir  [DEPTH];
    logic [1:0]         src_op   [DEPTH];
    logic [TAGW-1:0]    src_tag  [DEPTH];
    logic               src_err  [DEPTH];
    logic [AMT_EXT-1:0] amt_ext  [DEPTH];
    logic [WIDTH-1:0]   data_n   [DEPTH];

    logic sat0;
    logic advance;

    assign out_valid = vld_p[DEPTH-1];
    assign data_out  = data_p[DEPTH-1];
    assign tag_out   = tag_p[DEPTH-1];
    assign op_err    = err_p[DEPTH-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    always_comb begin
        // Stage 0 input: saturation resolved from the amount MSB, rotate ignores it.
        sat0        = shift_amt[SHIFTW] && (op != OP_ROT);
        src_data[0] = sat0 ? sat_fill(data_in, direction, op) : data_in;
        src_amt[0]  = sat0 ? '0 : shift_amt[SHIFTW-1:0];
        src_dir[0]  = direction;
        src_op[0]   = op;
        src_tag[0]  = tag_in;
        src_err[0]  = (op == OP_RSV);
        for (int s = 1; s < DEPTH; s++) begin
            src_data[s] = data_p[s-1];
            src_amt[s]  = amt_p[s-1];
            src_dir[s]  = dir_p[s-1];
            src_op[s]   = op_p[s-1];
            src_tag[s]  = tag_p[s-1];
            src_err[s]  = err_p[s-1];
        end
        // Each stage applies its own slice of levels, LSB level first.
        for (int s = 0; s < DEPTH; s++) begin
            amt_ext[s] = AMT_EXT'(src_amt[s]);
            data_n[s]  = src_data[s];
            for (int l = 0; l < LEVELS_PER_STAGE; l++) begin
                if (amt_ext[s][s*LEVELS_PER_STAGE + l]) begin
                    data_n[s] = shift_level(data_n[s], 1 << (s*LEVELS_PER_STAGE + l),
                                            src_dir[s], src_op[s]);
                end
            end
        end
    end

    // Stage registers; the last stage doubles as the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) vld_p[s] <= 1'b0;
            data_p[DEPTH-1] <= '0;
            tag_p[DEPTH-1]  <= '0;
            err_p[DEPTH-1]  <= 1'b0;
        end else if (advance) begin
            vld_p[0] <= in_valid;
            for (int s = 1; s < DEPTH; s++) vld_p[s] <= vld_p[s-1];
            for (int s = 0; s < DEPTH; s++) begin
                data_p[s] <= data_n[s];
                amt_p[s]  <= src_amt[s];
                dir_p[s]  <= src_dir[s];
                op_p[s]   <= src_op[s];
                tag_p[s]  <= src_tag[s];
                err_p[s]  <= src_err[s];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed and random ops checked by a scoreboard
// fed from an arithmetic reference model.
module tb_pipelined_barrel_shifter;

    localparam int W   = 32;
    localparam int L   = 2;
    localparam int TW  = 4;
    localparam int SW  = $clog2(W);
    localparam int LAT = (SW + L - 1) / L;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data_in;
    logic [SW:0]   shift_amt;
    logic          direction;
    logic [1:0]    op;
    logic [TW-1:0] tag_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  data_out;
    logic [TW-1:0] tag_out;
    logic          op_err;

    pipelined_barrel_shifter #(
        .WIDTH(W), .LEVELS_PER_STAGE(L), .TAGW(TW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_amt(shift_amt), .direction(direction), .op(op),
        .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .tag_out(tag_out), .op_err(op_err)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] tag;
        logic          err;
        int            acc;
    } exp_t;

    exp_t          q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            exact_lat = 0;
    bit            stalled_prev = 0;
    logic [W-1:0]  held_d;
    logic [TW-1:0] held_t;
    logic          held_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference behaviour straight from the operation rules.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt,
                                           input logic dir, input logic [1:0] o);
        logic [2*W-1:0] dd;
        logic [2*W-1:0] r;
        int a;
        if (o == 2'b10) begin
            a  = amt % W;
            dd = {d, d};
            if (dir) begin
                r = dd >> a;
                return r[W-1:0];
            end
            r = dd << a;
            return r[2*W-1:W];
        end
        if (amt >= W) return (o == 2'b01 && dir && d[W-1]) ? {W{1'b1}} : {W{1'b0}};
        if (!dir) return d << amt;
        if (o == 2'b01) return $signed(d) >>> amt;
        return d >> amt;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // One clock: drive, sample just after the drive, then advance to the next falling edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [SW:0] a,
                        input logic dr, input logic [1:0] o, input logic [TW-1:0] t,
                        input logic ordy, input logic r, output bit accepted);
        exp_t e;
        in_valid  = v;
        data_in   = d;
        shift_amt = a;
        direction = dr;
        op        = o;
        tag_in    = t;
        out_ready = ordy;
        rst       = r;
        accepted  = 0;
        #1;
        if (!r) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data_out", data_out, e.d);
                    chk("tag_out", tag_out, e.tag);
                    chk("op_err", op_err, e.err);
                    if (exact_lat) chk("latency", cyc - e.acc, LAT);
                end
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", in_ready, 0);
                if (stalled_prev) begin
                    chk("held_data", data_out, held_d);
                    chk("held_tag", tag_out, held_t);
                    chk("held_err", op_err, held_e);
                end
                stalled_prev = 1;
                held_d = data_out;
                held_t = tag_out;
                held_e = op_err;
            end else begin
                stalled_prev = 0;
            end
            if (in_valid && in_ready) begin
                e.d   = model(d, int'(a), dr, o);
                e.tag = t;
                e.err = (o == 2'b11);
                e.acc = cyc;
                q.push_back(e);
                accepted = 1;
            end
        end else begin
            stalled_prev = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [SW:0] a, input logic dr,
                        input logic [1:0] o, input logic [TW-1:0] t);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        while (!acc && n < 20) begin
            step(1'b1, d, a, dr, o, t, 1'b1, 1'b0, acc);
            n++;
        end
        chk("send_accepted", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            step(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b1, 1'b0, acc);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit acc;
        rst = 1'b1; in_valid = 1'b0; data_in = '0; shift_amt = '0;
        direction = 1'b0; op = 2'b00; tag_in = '0; out_ready = 1'b1;
        @(negedge clk);
        step(1'b1, 32'hDEAD_BEEF, 6'd3, 1'b0, 2'b00, 4'd7, 1'b1, 1'b1, acc);
        step(1'b1, 32'hDEAD_BEEF, 6'd3, 1'b0, 2'b00, 4'd7, 1'b1, 1'b1, acc);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_tag_out", tag_out, 0);
        chk("rst_op_err", op_err, 0);
        chk("rst_in_ready", in_ready, 1);

        exact_lat = 1;
        send(32'h0000_00F1, 7'd4, 1'b0, 2'b00, 4'd3);
        send(32'h8000_0010, 7'd4, 1'b1, 2'b01, 4'd4);
        send(32'h8000_0010, 7'd40, 1'b1, 2'b01, 4'd5);
        send(32'h8000_0010, 7'd40, 1'b1, 2'b00, 4'd6);
        send(32'h1234_5678, 7'd8, 1'b1, 2'b10, 4'd7);
        send(32'h1234_5678, 7'd36, 1'b0, 2'b10, 4'd8);
        send(32'h1234_5678, 7'd32, 1'b0, 2'b10, 4'd9);
        send(32'h1234_5678, 7'd32, 1'b1, 2'b10, 4'd10);
        send(32'hA5C3_0F96, 7'd0, 1'b1, 2'b01, 4'd11);
        send(32'hA5C3_0F96, 7'd0, 1'b0, 2'b00, 4'd12);
        send(32'hA5C3_0F96, 7'd31, 1'b1, 2'b01, 4'd13);
        send(32'h7FFF_FFFF, 7'd63, 1'b1, 2'b01, 4'd14);
        send(32'hF000_000F, 7'd63, 1'b0, 2'b10, 4'd15);
        send(32'h0000_0001, 7'd1, 1'b0, 2'b11, 4'd1);
        send(32'h0000_0001, 7'd1, 1'b0, 2'b00, 4'd2);
        drain();

        for (int i = 0; i < 10; i++)
            send($urandom, 7'($urandom_range(0, 63)), 1'($urandom), 2'($urandom), 4'(i));
        drain();

        exact_lat = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                for (int k = 0; k < 4; k++)
                    step(1'b1, 32'h0BAD_0BAD, 7'd3, 1'b0, 2'b00, 4'd5, 1'b0, 1'b0, acc);
            end
            send(32'h0101_0101 * (i + 1), 7'(i * 3), 1'(i), 2'(i), 4'(i));
        end
        drain();

        exact_lat = 1;
        send(32'h1111_1111, 7'd1, 1'b0, 2'b00, 4'd10);
        send(32'h2222_2222, 7'd2, 1'b0, 2'b00, 4'd11);
        send(32'h3333_3333, 7'd3, 1'b0, 2'b00, 4'd12);
        step(1'b1, 32'h4444_4444, 7'd4, 1'b0, 2'b00, 4'd13, 1'b0, 1'b1, acc);
        q.delete();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_data_out", data_out, 0);
        send(32'h0000_ABCD, 7'd8, 1'b0, 2'b00, 4'd9);
        drain();

        exact_lat = 0;
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom, 7'($urandom_range(0, 63)),
                 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'b0, acc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
